// File: rtl/cdcsync_l2l_mc.sv
// Purpose: multi-channel level synchronizer into des_clk with optional stability filter; edge detector when CDCSYNC_L2L_EDGE_EN is defined.
// Latency: FLOP_N des_clk edges from src_lvl to des_lvl, plus FILT_N edges when the filter is enabled (FILT_N>0).
// Backpressure: none; levels are sampled every cycle and pulses are single-cycle, never stalled.
module cdcsync_l2l_mc #(
    parameter int              CH_N    = 4,
    parameter int              FLOP_N  = 2,
    parameter int              FILT_N  = 0,
    parameter logic [CH_N-1:0] RST_VAL = '0
) (
    input  logic            des_clk,
    input  logic            des_rstn,
    input  logic [CH_N-1:0] src_lvl,
    output logic [CH_N-1:0] des_lvl,
    output logic [CH_N-1:0] des_rise,
    output logic [CH_N-1:0] des_fall,
    output logic            des_chg
);

    // Stage 0 is the metastability-catching flop; nothing may sit between stages.
    logic [CH_N-1:0] sync_q [FLOP_N];
    logic [CH_N-1:0] last_stage;

    // Plain shift chain per channel, all channels side by side.
    always_ff @(posedge des_clk or negedge des_rstn) begin
        if (!des_rstn) begin
            for (int s = 0; s < FLOP_N; s++) begin
                sync_q[s] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= src_lvl;
            for (int s = 1; s < FLOP_N; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign last_stage = sync_q[FLOP_N-1];

    generate
        if (FILT_N == 0) begin : g_nofilt
            assign des_lvl = last_stage;
        end else begin : g_filt
            localparam int CW = $clog2(FILT_N + 1);
            logic [CW-1:0]   cnt_q [CH_N];
            logic [CH_N-1:0] lvl_q;

            // A channel only adopts a new level after it has differed for FILT_N consecutive edges.
            always_ff @(posedge des_clk or negedge des_rstn) begin
                if (!des_rstn) begin
                    lvl_q <= RST_VAL;
                    for (int c = 0; c < CH_N; c++) begin
                        cnt_q[c] <= '0;
                    end
                end else begin
                    for (int c = 0; c < CH_N; c++) begin
                        if (last_stage[c] == lvl_q[c]) begin
                            cnt_q[c] <= '0;
                        end else if (cnt_q[c] == CW'(FILT_N - 1)) begin
                            lvl_q[c] <= last_stage[c];
                            cnt_q[c] <= '0;
                        end else begin
                            cnt_q[c] <= cnt_q[c] + CW'(1);
                        end
                    end
                end
            end

            assign des_lvl = lvl_q;
        end
    endgenerate

`ifdef CDCSYNC_L2L_EDGE_EN
    logic [CH_N-1:0] hist_q;

    // One-cycle-old copy of des_lvl; reset to RST_VAL so release alone never pulses.
    always_ff @(posedge des_clk or negedge des_rstn) begin
        if (!des_rstn) begin
            hist_q <= RST_VAL;
        end else begin
            hist_q <= des_lvl;
        end
    end

    assign des_rise = des_lvl & ~hist_q;
    assign des_fall = ~des_lvl & hist_q;
    assign des_chg  = |(des_rise | des_fall);
`else
    assign des_rise = '0;
    assign des_fall = '0;
    assign des_chg  = 1'b0;
`endif

endmodule

// File: tb/tb_cdcsync_l2l_mc.sv
// Purpose: directed check of reset, latency, filtering, simultaneous edges and mid-filter reset.
// Latency: outputs sampled 1 time unit after each rising des_clk edge.
// Backpressure: not applicable.
module tb_cdcsync_l2l_mc;

`ifdef CDCSYNC_L2L_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif

    logic       des_clk = 1'b0;
    logic       des_rstn = 1'b0;

    logic [3:0] src_r, lvl_r, rise_r, fall_r;
    logic       chg_r;
    logic [3:0] src_0, lvl_0, rise_0, fall_0;
    logic       chg_0;
    logic [3:0] src_3, lvl_3, rise_3, fall_3;
    logic       chg_3;

    int vectors = 0;
    int fails   = 0;

    always #5 des_clk = ~des_clk;

    cdcsync_l2l_mc #(.CH_N(4), .FLOP_N(2), .FILT_N(0), .RST_VAL(4'h5)) dut_r (
        .des_clk(des_clk), .des_rstn(des_rstn), .src_lvl(src_r),
        .des_lvl(lvl_r), .des_rise(rise_r), .des_fall(fall_r), .des_chg(chg_r));

    cdcsync_l2l_mc #(.CH_N(4), .FLOP_N(2), .FILT_N(0), .RST_VAL(4'h0)) dut_0 (
        .des_clk(des_clk), .des_rstn(des_rstn), .src_lvl(src_0),
        .des_lvl(lvl_0), .des_rise(rise_0), .des_fall(fall_0), .des_chg(chg_0));

    cdcsync_l2l_mc #(.CH_N(4), .FLOP_N(2), .FILT_N(3), .RST_VAL(4'h0)) dut_3 (
        .des_clk(des_clk), .des_rstn(des_rstn), .src_lvl(src_3),
        .des_lvl(lvl_3), .des_rise(rise_3), .des_fall(fall_3), .des_chg(chg_3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge des_clk);
        #1;
    endtask

    logic [3:0] e4;

    initial begin
        src_r = 4'hF;
        src_0 = 4'h0;
        src_3 = 4'h0;
        des_rstn = 1'b0;
        tick(2);

        // Reset state
        chk("rst_lvl_r", lvl_r, 4'h5);
        chk("rst_rise_r", rise_r, 4'h0);
        chk("rst_fall_r", fall_r, 4'h0);
        chk("rst_chg_r", chg_r, 0);
        chk("rst_lvl_0", lvl_0, 4'h0);
        chk("rst_lvl_3", lvl_3, 4'h0);

        // Release with src equal to RST_VAL: quiet for 20 cycles
        src_r = 4'h5;
        des_rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("rel_lvl_r", lvl_r, 4'h5);
            chk("rel_pulse_r", {rise_r, fall_r, chg_r}, 0);
        end

        // Latency, FILT_N=0
        src_0 = 4'h1;
        tick(1);
        chk("lat_e1_lvl", lvl_0, 4'h0);
        chk("lat_e1_chg", chg_0, 0);
        tick(1);
        chk("lat_e2_lvl", lvl_0, 4'h1);
        e4 = EDGE ? 4'h1 : 4'h0;
        chk("lat_e2_rise", rise_0, e4);
        chk("lat_e2_chg", chg_0, EDGE);
        tick(1);
        chk("lat_e3_lvl", lvl_0, 4'h1);
        chk("lat_e3_rise", rise_0, 4'h0);
        chk("lat_e3_chg", chg_0, 0);

        // Simultaneous change on all channels
        src_0 = 4'h0;
        tick(3);
        chk("sim_pre_lvl", lvl_0, 4'h0);
        chk("sim_pre_chg", chg_0, 0);
        src_0 = 4'hF;
        tick(1);
        chk("sim_e1_lvl", lvl_0, 4'h0);
        tick(1);
        chk("sim_e2_lvl", lvl_0, 4'hF);
        e4 = EDGE ? 4'hF : 4'h0;
        chk("sim_e2_rise", rise_0, e4);
        chk("sim_e2_fall", fall_0, 4'h0);
        chk("sim_e2_chg", chg_0, EDGE);
        tick(1);
        chk("sim_e3_rise", rise_0, 4'h0);
        chk("sim_e3_chg", chg_0, 0);

        // Filter: 2-cycle glitch on channel 1 is suppressed
        src_3 = 4'h2;
        tick(2);
        src_3 = 4'h0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_lvl", lvl_3, 4'h0);
            chk("glitch_pulse", {rise_3, fall_3, chg_3}, 0);
        end

        // Filter: 3-cycle pulse passes after FLOP_N+FILT_N = 5 edges
        src_3 = 4'h2;
        tick(3);
        src_3 = 4'h0;
        tick(1);
        chk("filt_e4_lvl", lvl_3, 4'h0);
        tick(1);
        chk("filt_e5_lvl", lvl_3, 4'h2);
        e4 = EDGE ? 4'h2 : 4'h0;
        chk("filt_e5_rise", rise_3, e4);
        chk("filt_e5_chg", chg_3, EDGE);
        tick(1);
        chk("filt_e6_lvl", lvl_3, 4'h2);
        chk("filt_e6_rise", rise_3, 4'h0);
        tick(1);
        chk("filt_e7_lvl", lvl_3, 4'h2);
        chk("filt_e7_fall", fall_3, 4'h0);
        tick(1);
        chk("filt_e8_lvl", lvl_3, 4'h0);
        chk("filt_e8_fall", fall_3, e4);
        chk("filt_e8_chg", chg_3, EDGE);
        tick(1);
        chk("filt_e9_fall", fall_3, 4'h0);
        chk("filt_e9_chg", chg_3, 0);

        // Reset while channel 2's counter holds 2
        src_3 = 4'h1;
        tick(6);
        chk("mid_pre_lvl", lvl_3, 4'h1);
        src_3 = 4'h5;
        tick(4);
        chk("mid_cnt2_lvl", lvl_3, 4'h1);
        des_rstn = 1'b0;
        #1;
        chk("mid_rst_lvl", lvl_3, 4'h0);
        chk("mid_rst_pulse", {rise_3, fall_3, chg_3}, 0);
        #2;
        des_rstn = 1'b1;
        tick(4);
        chk("mid_rel_e4_lvl", lvl_3, 4'h0);
        chk("mid_rel_e4_chg", chg_3, 0);
        tick(1);
        chk("mid_rel_e5_lvl", lvl_3, 4'h5);
        e4 = EDGE ? 4'h5 : 4'h0;
        chk("mid_rel_e5_rise", rise_3, e4);
        chk("mid_rel_e5_chg", chg_3, EDGE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/cdcsync_l2l_mc.md
CDCSYNC_L2L_MC -- requirements
Module: cdcsync_l2l_mc

Interface
REQ-001 SHALL have parameter CH_N, default 4: number of independent level channels (>=1).
REQ-002 SHALL have parameter FLOP_N, default 2: synchronizer stages per channel (>=2).
REQ-003 SHALL have parameter FILT_N, default 0: stability filter length in des_clk cycles (0 = filter bypassed).
REQ-004 SHALL have parameter RST_VAL, default '0: CH_N-bit reset value of the synchronizer flops, filter output and edge history.
REQ-005 SHALL have port des_clk  input  1  destination clock; the only clock in the block.
REQ-006 SHALL have port des_rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port src_lvl  input  CH_N  asynchronous levels, each driven from a flop in the source domain.
REQ-008 SHALL have port des_lvl  output  CH_N  synchronized (and filtered) levels.
REQ-009 SHALL have port des_rise  output  CH_N  one-cycle pulse per channel on a 0->1 of des_lvl.
REQ-010 SHALL have port des_fall  output  CH_N  one-cycle pulse per channel on a 1->0 of des_lvl.
REQ-011 SHALL have port des_chg  output  1  OR of all des_rise and des_fall bits.

Function
REQ-012 SHALL pass each src_lvl bit through its own FLOP_N-deep shift chain clocked by des_clk; no logic between stages.
REQ-013 SHALL, with FILT_N=0, drive des_lvl directly from the last chain stage: a src_lvl change setting up before edge k appears on des_lvl after edge k+FLOP_N-1 (FLOP_N edges).
REQ-014 SHALL, with FILT_N>0, hold a per-channel counter of width $clog2(FILT_N+1) and a registered des_lvl.
REQ-015 SHALL, at each edge per channel: if last stage == des_lvl, clear counter; else if counter == FILT_N-1, load des_lvl from last stage and clear counter; else increment counter.
REQ-016 SHALL therefore suppress any last-stage excursion shorter than FILT_N cycles and add exactly FILT_N cycles of latency (total FLOP_N+FILT_N).
REQ-017 SHALL never let a counter exceed FILT_N-1 or wrap.
REQ-018 SHALL keep channels fully independent; simultaneous changes on several channels update in the same cycle each would alone.
REQ-019 SHALL assert des_rise[i]/des_fall[i] combinationally as des_lvl[i] & ~hist[i] / ~des_lvl[i] & hist[i], hist being des_lvl delayed one des_clk; each pulse lasts exactly one cycle, in the first cycle des_lvl holds its new value.
REQ-020 SHALL assert des_chg for one cycle whenever any channel pulses, regardless of how many channels change together.

Reset
REQ-021 SHALL, while des_rstn is low, force all chain stages, des_lvl and hist to RST_VAL, all counters to 0, and des_rise, des_fall, des_chg to 0, asynchronously.
REQ-022 SHALL, on release, produce no edge pulse unless des_lvl subsequently departs from RST_VAL.
REQ-023 SHALL, on reset mid-filter, discard partial counts; filtering restarts from 0 after release.

Configuration
REQ-024 SHALL compile the edge detector (hist register, des_rise, des_fall, des_chg logic) only when macro CDCSYNC_L2L_EDGE_EN is defined.
REQ-025 SHALL, without CDCSYNC_L2L_EDGE_EN, keep all ports, tie des_rise, des_fall to '0 and des_chg to 0, and instantiate no hist flops; des_lvl behaviour identical.

Verification
REQ-026 SHALL cover reset: RST_VAL=4'h5, src_lvl=4'hF, des_rstn low -> des_lvl=4'h5, pulses 0; release with src_lvl=4'h5 held -> no pulse for 20 cycles.
REQ-027 SHALL cover latency: FILT_N=0, FLOP_N=2, src_lvl[0] 0->1 -> des_lvl[0] high 2 edges later, des_rise[0] and des_chg high exactly 1 cycle.
REQ-028 SHALL cover filter: FILT_N=3, FLOP_N=2, src_lvl[1] high 2 cycles -> des_lvl[1] unchanged, no pulse; high 3 cycles then low -> des_lvl[1] high 5 edges after rise for 3 cycles, then des_fall[1] once.
REQ-029 SHALL cover simultaneous events: src_lvl 4'h0->4'hF in one cycle -> des_lvl 4'hF same cycle, des_rise=4'hF, des_chg a single 1-cycle pulse.
REQ-030 SHALL cover reset mid-operation: FILT_N=3, assert des_rstn low when a counter is 2 -> outputs RST_VAL immediately; after release, full FLOP_N+3 latency required again.
REQ-031 SHALL cover macro off: build without CDCSYNC_L2L_EDGE_EN, rerun REQ-027 stimulus -> des_lvl identical, des_rise/des_fall/des_chg constant 0.
